// File: rtl/gumnut_control_unit_if.sv
// Instruction, data-memory and I/O-port bus handshakes between the Gumnut
// control unit (master) and the memory/port fabric (slave).
interface gumnut_control_unit_if #(
   parameter int PC_W = 12
) ();
   logic            inst_cyc_o;
   logic            inst_stb_o;
   logic [PC_W-1:0] inst_adr_o;
   logic            inst_ack_i;

   logic            data_cyc_o;
   logic            data_stb_o;
   logic            data_we_o;
   logic            data_ack_i;

   logic            port_cyc_o;
   logic            port_stb_o;
   logic            port_we_o;
   logic            port_ack_i;

   modport master (
      output inst_cyc_o, inst_stb_o, inst_adr_o,
      output data_cyc_o, data_stb_o, data_we_o,
      output port_cyc_o, port_stb_o, port_we_o,
      input  inst_ack_i, data_ack_i, port_ack_i
   );

   modport slave (
      input  inst_cyc_o, inst_stb_o, inst_adr_o,
      input  data_cyc_o, data_stb_o, data_we_o,
      input  port_cyc_o, port_stb_o, port_we_o,
      output inst_ack_i, data_ack_i, port_ack_i
   );
endinterface

// File: rtl/gumnut_control_unit.sv
// Gumnut sequencer: owns the PC and return stack, runs the bus handshakes and
// drives the datapath control strobes through FETCH/DECODE/EXECUTE/MEM/HALT.
module gumnut_control_unit #(
   parameter int RSTACK_DEPTH = 8,
   parameter int PC_W         = 12
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   gumnut_control_unit_if.master bus,
   input  logic [6:0]            op_e,
   input  logic [2:0]            func_e,
   input  logic [PC_W-1:0]       addr_e,
   input  logic [7:0]            disp_e,
   input  logic                  zero_e,
   input  logic                  carry_e,
   output logic                  RegWrt_c,
   output logic                  ClkEn_e,
   output logic [1:0]            RegMux_c,
   output logic                  op2_c,
   output logic                  halted_o
);
   localparam int SP_W = (RSTACK_DEPTH > 1) ? $clog2(RSTACK_DEPTH) : 1;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEM,
      S_HALT
   } state_t;

   state_t          r_state, w_state_next;
   logic            r_run;
   logic [PC_W-1:0] r_pc, w_pc_next;
   logic [SP_W-1:0] r_sp, w_sp_next, w_sp_dec;
   logic [PC_W-1:0] r_stack [RSTACK_DEPTH];
   logic [6:0]      r_class;
   logic [2:0]      r_func;
   logic            r_op2, r_z, r_c;

   logic            w_push, w_flag_upd, w_br_cond;
   logic            w_inst_act, w_mem_data, w_mem_port;
   logic            w_data_done, w_port_done;
   logic            w_class_ok, w_is_alu, w_op2_dec;
   logic [PC_W-1:0] w_disp_ext;

   // r_run keeps the fetch strobe low until the first clock after reset.
   assign w_inst_act  = r_run && (r_state == S_FETCH);
   assign w_mem_data  = (r_state == S_MEM) && !r_func[1];
   assign w_mem_port  = (r_state == S_MEM) &&  r_func[1];
   assign w_data_done = w_mem_data && bus.data_ack_i;
   assign w_port_done = w_mem_port && bus.port_ack_i;

   assign w_class_ok = (r_class != 7'd0) && ((r_class & (r_class - 7'd1)) == 7'd0);
   assign w_is_alu   = w_class_ok && (r_class[0] || r_class[1] || r_class[2]);
   assign w_op2_dec  = (op_e == 7'b0000010) || ((op_e == 7'b0000100) && func_e[2]);
   assign w_disp_ext = {{(PC_W-8){disp_e[7]}}, disp_e};
   assign w_sp_dec   = r_sp - SP_W'(1);

   always_comb begin
      w_br_cond = 1'b0;
      case (r_func[1:0])
         2'b00:   w_br_cond =  r_z;
         2'b01:   w_br_cond = !r_z;
         2'b10:   w_br_cond =  r_c;
         default: w_br_cond = !r_c;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_sp_next    = r_sp;
      w_push       = 1'b0;
      w_flag_upd   = 1'b0;
      RegWrt_c     = 1'b0;
      ClkEn_e      = 1'b0;
      RegMux_c     = 2'b00;
      case (r_state)
         S_FETCH: begin
            if (w_inst_act && bus.inst_ack_i) begin
               w_pc_next    = r_pc + PC_W'(1);
               w_state_next = S_DECODE;
            end
         end
         S_DECODE: w_state_next = S_EXECUTE;
         S_EXECUTE: begin
            w_state_next = S_FETCH;
            if (w_is_alu) begin
               RegWrt_c   = 1'b1;
               ClkEn_e    = 1'b1;
               w_flag_upd = 1'b1;
            end else if (w_class_ok && r_class[4]) begin
               if (w_br_cond) w_pc_next = r_pc + w_disp_ext;
            end else if (w_class_ok && r_class[5]) begin
               w_pc_next = addr_e;
               if (r_func[0]) begin
                  w_push    = 1'b1;
                  w_sp_next = r_sp + SP_W'(1);
               end
            end else if (w_class_ok && r_class[6]) begin
               if (r_func == 3'b000) begin
                  w_pc_next = r_stack[w_sp_dec];
                  w_sp_next = w_sp_dec;
               end else if (r_func == 3'b001) begin
                  w_state_next = S_HALT;
               end
            end else if (w_class_ok && r_class[3]) begin
               w_state_next = S_MEM;
            end
         end
         S_MEM: begin
            // Writeback select is held for the whole access so it is stable at the ack.
            if (!r_func[0]) RegMux_c = r_func[1] ? 2'b10 : 2'b01;
            if (w_data_done || w_port_done) begin
               w_state_next = S_FETCH;
               if (!r_func[0]) begin
                  RegWrt_c = 1'b1;
                  ClkEn_e  = 1'b1;
               end
            end
         end
         S_HALT:  w_state_next = S_HALT;
         default: w_state_next = S_FETCH;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= S_FETCH;
         r_run   <= 1'b0;
         r_pc    <= '0;
         r_sp    <= '0;
         r_class <= '0;
         r_func  <= '0;
         r_op2   <= 1'b0;
         r_z     <= 1'b0;
         r_c     <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_run   <= 1'b1;
         r_pc    <= w_pc_next;
         r_sp    <= w_sp_next;
         r_op2   <= (r_state == S_DECODE) ? w_op2_dec : 1'b0;
         if (r_state == S_DECODE) begin
            r_class <= op_e;
            r_func  <= func_e;
         end
         if (w_flag_upd) begin
            r_z <= zero_e;
            r_c <= carry_e;
         end
      end
   end

   // Return-stack contents need no reset; only the pointer defines validity.
   always_ff @(posedge clk_i) begin
      if (w_push) r_stack[r_sp] <= r_pc;
   end

   assign bus.inst_cyc_o = w_inst_act;
   assign bus.inst_stb_o = w_inst_act;
   assign bus.inst_adr_o = r_pc;
   assign bus.data_cyc_o = w_mem_data;
   assign bus.data_stb_o = w_mem_data;
   assign bus.data_we_o  = w_mem_data && r_func[0];
   assign bus.port_cyc_o = w_mem_port;
   assign bus.port_stb_o = w_mem_port;
   assign bus.port_we_o  = w_mem_port && r_func[0];
   assign op2_c          = r_op2;
   assign halted_o       = (r_state == S_HALT);
endmodule

// File: tb/tb_gumnut_control_unit.sv
// Directed testbench for gumnut_control_unit: reset/fetch, ALU+branch,
// subroutine nesting, memory/port access, mid-op reset, standby, illegal class.
module tb_gumnut_control_unit;
   localparam logic [6:0] C_AREG = 7'b0000001;
   localparam logic [6:0] C_AIMM = 7'b0000010;
   localparam logic [6:0] C_MEM  = 7'b0001000;
   localparam logic [6:0] C_BR   = 7'b0010000;
   localparam logic [6:0] C_JMP  = 7'b0100000;
   localparam logic [6:0] C_MISC = 7'b1000000;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0;
   logic [6:0]  op_e = '0;
   logic [2:0]  func_e = '0;
   logic [11:0] addr_e = '0;
   logic [7:0]  disp_e = '0;
   logic        zero_e = 1'b0;
   logic        carry_e = 1'b0;
   logic        RegWrt_c, ClkEn_e, op2_c, halted_o;
   logic [1:0]  RegMux_c;
   int          n_vec = 0;
   int          n_err = 0;

   gumnut_control_unit_if #(.PC_W(12)) bus ();

   gumnut_control_unit #(.RSTACK_DEPTH(8), .PC_W(12)) dut (
      .clk_i(clk), .rst_i(rst_i), .bus(bus),
      .op_e(op_e), .func_e(func_e), .addr_e(addr_e), .disp_e(disp_e),
      .zero_e(zero_e), .carry_e(carry_e),
      .RegWrt_c(RegWrt_c), .ClkEn_e(ClkEn_e), .RegMux_c(RegMux_c),
      .op2_c(op2_c), .halted_o(halted_o)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst_i = 1'b0;
      bus.inst_ack_i = 1'b0; bus.data_ack_i = 1'b0; bus.port_ack_i = 1'b0;
      repeat (2) @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
   endtask

   // Waits for the fetch strobe, acks it after 'waits' cycles and presents the
   // decoded fields; returns at the DECODE-cycle negedge with the fetch address.
   task automatic fetch(input int waits, input logic [6:0] op, input logic [2:0] fn,
                        input logic [11:0] a, input logic [7:0] d, input logic z,
                        input logic c, output logic [11:0] adr);
      int n = 0;
      while (bus.inst_stb_o !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         n_vec++; n_err++;
         $display("FAIL fetch_timeout: got inst_stb_o=%b required 1", bus.inst_stb_o);
         adr = 'x;
         return;
      end
      adr = bus.inst_adr_o;
      repeat (waits) @(negedge clk);
      bus.inst_ack_i = 1'b1;
      op_e = op; func_e = fn; addr_e = a; disp_e = d; zero_e = z; carry_e = c;
      @(negedge clk);
      bus.inst_ack_i = 1'b0;
   endtask

   task automatic instr(input logic [6:0] op, input logic [2:0] fn, input logic [11:0] a,
                        input logic [7:0] d, input logic z, input logic c, output logic [11:0] adr);
      fetch(0, op, fn, a, d, z, c, adr);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk); @(negedge clk);
      n_vec++;
      if ({bus.inst_cyc_o, bus.inst_stb_o, bus.data_cyc_o, bus.data_stb_o, bus.data_we_o,
           bus.port_cyc_o, bus.port_stb_o, bus.port_we_o, RegWrt_c, ClkEn_e, RegMux_c,
           op2_c, halted_o} !== 14'd0)
         begin n_err++; $display("FAIL reset_outputs: got nonzero output(s) required all 0"); end
      n_vec++;
      if (bus.inst_adr_o !== 12'h000) begin n_err++; $display("FAIL reset_pc: got %h required 000", bus.inst_adr_o); end
      rst_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_vec++;
         if ({bus.inst_stb_o, bus.inst_adr_o} !== {1'b1, 12'h000}) begin
            n_err++; $display("FAIL first_fetch_c%0d: got stb=%b adr=%h required stb=1 adr=000", i, bus.inst_stb_o, bus.inst_adr_o);
         end
      end
      bus.inst_ack_i = 1'b1; op_e = C_MISC; func_e = 3'b010;
      @(negedge clk);
      bus.inst_ack_i = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({bus.inst_stb_o, bus.inst_adr_o} !== {1'b1, 12'h001}) begin
         n_err++; $display("FAIL second_fetch: got stb=%b adr=%h required stb=1 adr=001", bus.inst_stb_o, bus.inst_adr_o);
      end
   endtask

   task automatic test_alu_branch();
      logic [11:0] a;
      do_reset();
      instr(C_JMP, 3'b000, 12'h010, 8'h00, 1'b0, 1'b0, a);
      fetch(0, C_AIMM, 3'b000, 12'h000, 8'h00, 1'b1, 1'b0, a);
      n_vec++;
      if (a !== 12'h010) begin n_err++; $display("FAIL jmp_target: got %h required 010", a); end
      @(negedge clk);
      n_vec++;
      if (op2_c !== 1'b1) begin n_err++; $display("FAIL alu_imm_op2: got %b required 1", op2_c); end
      n_vec++;
      if ({RegWrt_c, ClkEn_e, RegMux_c} !== 4'b1100) begin
         n_err++; $display("FAIL alu_wb: got %b required 1100", {RegWrt_c, ClkEn_e, RegMux_c});
      end
      @(negedge clk);
      n_vec++;
      if ({RegWrt_c, ClkEn_e, op2_c, bus.inst_stb_o} !== 4'b0001) begin
         n_err++; $display("FAIL alu_pulse_end: got %b required 0001", {RegWrt_c, ClkEn_e, op2_c, bus.inst_stb_o});
      end
      instr(C_BR, 3'b000, 12'h000, 8'hFC, 1'b0, 1'b1, a);   // bz -4, live flags disagree
      n_vec++;
      if (a !== 12'h011) begin n_err++; $display("FAIL bz_fetch_adr: got %h required 011", a); end
      instr(C_BR, 3'b011, 12'h000, 8'h02, 1'b0, 1'b1, a);   // bnc +2
      n_vec++;
      if (a !== 12'h00E) begin n_err++; $display("FAIL bz_taken: got %h required 00E", a); end
      instr(C_BR, 3'b010, 12'h000, 8'h05, 1'b0, 1'b0, a);   // bc +5
      n_vec++;
      if (a !== 12'h011) begin n_err++; $display("FAIL bnc_taken: got %h required 011", a); end
      instr(C_AREG, 3'b000, 12'h000, 8'h00, 1'b0, 1'b1, a); // Z=0 C=1
      n_vec++;
      if (a !== 12'h012) begin n_err++; $display("FAIL bc_not_taken: got %h required 012", a); end
      instr(C_BR, 3'b001, 12'h000, 8'h10, 1'b1, 1'b0, a);   // bnz +16
      instr(C_MISC, 3'b010, 12'h000, 8'h00, 1'b0, 1'b0, a);
      n_vec++;
      if (a !== 12'h024) begin n_err++; $display("FAIL bnz_taken: got %h required 024", a); end
   endtask

   task automatic test_subroutine();
      logic [11:0] a;
      logic [11:0] exp_pc;
      logic [11:0] ret_adr [9];
      for (int k = 0; k < 9; k++) ret_adr[k] = (k == 0) ? 12'h101 : 12'h201 + 12'(16 * (k - 1));
      do_reset();
      instr(C_JMP, 3'b000, 12'h100, 8'h00, 1'b0, 1'b0, a);
      for (int k = 0; k < 9; k++) begin
         instr(C_JMP, 3'b001, 12'h200 + 12'(16 * k), 8'h00, 1'b0, 1'b0, a);
         exp_pc = (k == 0) ? 12'h100 : 12'h200 + 12'(16 * (k - 1));
         n_vec++;
         if (a !== exp_pc) begin n_err++; $display("FAIL jsb%0d_adr: got %h required %h", k, a, exp_pc); end
      end
      exp_pc = 12'h280;
      for (int r = 0; r < 9; r++) begin
         instr(C_MISC, 3'b000, 12'h000, 8'h00, 1'b0, 1'b0, a);
         n_vec++;
         if (a !== exp_pc) begin n_err++; $display("FAIL ret%0d_adr: got %h required %h", r, a, exp_pc); end
         exp_pc = (r < 8) ? ret_adr[8 - r] : ret_adr[8];
      end
      instr(C_JMP, 3'b000, 12'hFFF, 8'h00, 1'b0, 1'b0, a);
      n_vec++;
      if (a !== 12'h271) begin n_err++; $display("FAIL ret_wrapped: got %h required 271", a); end
      instr(C_MISC, 3'b010, 12'h000, 8'h00, 1'b0, 1'b0, a);
      n_vec++;
      if (a !== 12'hFFF) begin n_err++; $display("FAIL pc_top: got %h required FFF", a); end
      instr(C_MISC, 3'b010, 12'h000, 8'h00, 1'b0, 1'b0, a);
      n_vec++;
      if (a !== 12'h000) begin n_err++; $display("FAIL pc_wrap: got %h required 000", a); end
   endtask

   task automatic test_mem();
      logic [11:0] a;
      do_reset();
      instr(C_JMP, 3'b000, 12'h040, 8'h00, 1'b0, 1'b0, a);
      fetch(0, C_MEM, 3'b000, 12'h000, 8'h00, 1'b0, 1'b0, a);  // ldm
      repeat (2) @(negedge clk);
      bus.port_ack_i = 1'b1;    // stray ack on the wrong bus
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin bus.data_ack_i = 1'b1; #1; end
         n_vec++;
         if ({bus.data_stb_o, bus.data_we_o, RegWrt_c} !== {1'b1, 1'b0, i == 2}) begin
            n_err++; $display("FAIL ldm_wait_c%0d: got stb/we/wrt=%b required %b", i,
                              {bus.data_stb_o, bus.data_we_o, RegWrt_c}, {1'b1, 1'b0, i == 2});
         end
         if (i < 2) @(negedge clk);
         bus.port_ack_i = 1'b0;
      end
      n_vec++;
      if ({ClkEn_e, RegMux_c} !== 3'b101) begin n_err++; $display("FAIL ldm_wb: got %b required 101", {ClkEn_e, RegMux_c}); end
      @(negedge clk);
      bus.data_ack_i = 1'b0;
      n_vec++;
      if ({bus.data_stb_o, RegWrt_c, bus.inst_stb_o, bus.inst_adr_o} !== {3'b001, 12'h041}) begin
         n_err++; $display("FAIL ldm_done: got stb=%b wrt=%b istb=%b adr=%h required 0 0 1 041",
                           bus.data_stb_o, RegWrt_c, bus.inst_stb_o, bus.inst_adr_o);
      end
      fetch(0, C_MEM, 3'b011, 12'h000, 8'h00, 1'b0, 1'b0, a);  // out
      repeat (2) @(negedge clk);
      n_vec++;
      if ({bus.port_stb_o, bus.port_we_o, bus.data_stb_o} !== 3'b110) begin
         n_err++; $display("FAIL out_strobe: got %b required 110", {bus.port_stb_o, bus.port_we_o, bus.data_stb_o});
      end
      bus.port_ack_i = 1'b1; bus.data_ack_i = 1'b1; #1;
      n_vec++;
      if ({RegWrt_c, ClkEn_e} !== 2'b00) begin n_err++; $display("FAIL out_no_wb: got %b required 00", {RegWrt_c, ClkEn_e}); end
      @(negedge clk);
      bus.port_ack_i = 1'b0; bus.data_ack_i = 1'b0;
      n_vec++;
      if ({bus.port_stb_o, bus.inst_stb_o, bus.inst_adr_o} !== {2'b01, 12'h042}) begin
         n_err++; $display("FAIL out_done: got pstb=%b istb=%b adr=%h required 0 1 042", bus.port_stb_o, bus.inst_stb_o, bus.inst_adr_o);
      end
      fetch(0, C_MEM, 3'b010, 12'h000, 8'h00, 1'b0, 1'b0, a);  // inp
      repeat (2) @(negedge clk);
      bus.port_ack_i = 1'b1; #1;
      n_vec++;
      if ({bus.port_stb_o, bus.port_we_o, RegWrt_c, ClkEn_e, RegMux_c} !== 6'b101110) begin
         n_err++; $display("FAIL inp_wb: got %b required 101110", {bus.port_stb_o, bus.port_we_o, RegWrt_c, ClkEn_e, RegMux_c});
      end
      @(negedge clk);
      bus.port_ack_i = 1'b0;
   endtask

   task automatic test_reset_and_halt();
      logic [11:0] a;
      do_reset();
      fetch(0, C_MEM, 3'b001, 12'h000, 8'h00, 1'b0, 1'b0, a);  // stm, never acked
      repeat (2) @(negedge clk);
      n_vec++;
      if ({bus.data_stb_o, bus.data_we_o} !== 2'b11) begin n_err++; $display("FAIL stm_strobe: got %b required 11", {bus.data_stb_o, bus.data_we_o}); end
      #2 rst_i = 1'b0;
      #1;
      n_vec++;
      if ({bus.data_stb_o, bus.data_we_o, bus.inst_stb_o, bus.inst_adr_o} !== {3'b000, 12'h000}) begin
         n_err++; $display("FAIL async_reset: got dstb=%b we=%b istb=%b adr=%h required 0 0 0 000",
                           bus.data_stb_o, bus.data_we_o, bus.inst_stb_o, bus.inst_adr_o);
      end
      @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      fetch(0, C_MISC, 3'b001, 12'h000, 8'h00, 1'b0, 1'b0, a);  // stby
      n_vec++;
      if (a !== 12'h000) begin n_err++; $display("FAIL restart_adr: got %h required 000", a); end
      repeat (2) @(negedge clk);
      bus.inst_ack_i = 1'b1;
      for (int i = 0; i < 100; i++) begin
         n_vec++;
         if ({halted_o, bus.inst_stb_o, bus.data_stb_o, bus.port_stb_o, RegWrt_c} !== 5'b10000) begin
            n_err++; $display("FAIL halt_c%0d: got %b required 10000", i,
                              {halted_o, bus.inst_stb_o, bus.data_stb_o, bus.port_stb_o, RegWrt_c});
            break;
         end
         @(negedge clk);
      end
      bus.inst_ack_i = 1'b0;
      rst_i = 1'b0; #1;
      n_vec++;
      if (halted_o !== 1'b0) begin n_err++; $display("FAIL halt_exit: got %b required 0", halted_o); end
      @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_illegal();
      logic [11:0] a;
      do_reset();
      fetch(0, 7'h00, 3'b000, 12'h000, 8'h00, 1'b0, 1'b0, a);
      @(negedge clk);
      n_vec++;
      if ({RegWrt_c, ClkEn_e, op2_c} !== 3'b000) begin n_err++; $display("FAIL empty_op: got %b required 000", {RegWrt_c, ClkEn_e, op2_c}); end
      @(negedge clk);
      fetch(0, 7'h03, 3'b100, 12'h000, 8'h00, 1'b0, 1'b0, a);
      n_vec++;
      if (a !== 12'h001) begin n_err++; $display("FAIL empty_op_pc: got %h required 001", a); end
      @(negedge clk);
      n_vec++;
      if ({RegWrt_c, ClkEn_e, op2_c} !== 3'b000) begin n_err++; $display("FAIL multi_hot_op: got %b required 000", {RegWrt_c, ClkEn_e, op2_c}); end
      @(negedge clk);
      n_vec++;
      if ({bus.inst_stb_o, bus.inst_adr_o} !== {1'b1, 12'h002}) begin
         n_err++; $display("FAIL multi_hot_pc: got stb=%b adr=%h required 1 002", bus.inst_stb_o, bus.inst_adr_o);
      end
   endtask

   initial begin
      bus.inst_ack_i = 1'b0;
      bus.data_ack_i = 1'b0;
      bus.port_ack_i = 1'b0;
      test_reset();
      test_alu_branch();
      test_subroutine();
      test_mem();
      test_reset_and_halt();
      test_illegal();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/gumnut_control_unit.md
# gumnut_control_unit

Sequencer for the Gumnut-style core. It sits directly upstream of the datapath unit: it owns the program counter and the instruction, data and port bus handshakes, and it drives the datapath's control strobes (register write, clock enable, writeback mux select, operand-2 select). It consumes the decoded opcode class, function code, jump/branch targets and ALU flags that the datapath returns.

## Interface
Parameters:
- RSTACK_DEPTH, 8: return-address stack entries. Must be a power of two.
- PC_W, 12: program counter width. Matches the datapath `addr_e` width.

Ports:
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous reset, active-low
- inst_cyc_o / inst_stb_o  out  1  instruction fetch request
- inst_adr_o  out  PC_W  fetch address (PC)
- inst_ack_i  in  1  instruction valid; the datapath latches the instruction on this
- op_e  in  7  one-hot opcode class: [0] alu_reg, [1] alu_imm, [2] shift, [3] mem, [4] branch, [5] jump, [6] misc
- func_e  in  3  function within class
- addr_e  in  PC_W  absolute jump target
- disp_e  in  8  signed branch displacement
- zero_e, carry_e  in  1  ALU flags for the current instruction
- data_cyc_o / data_stb_o, data_we_o  out  1  data memory request, write enable
- data_ack_i  in  1  data memory done
- port_cyc_o / port_stb_o, port_we_o  out  1  I/O port request, write enable
- port_ack_i  in  1  port done
- RegWrt_c  out  1  register file write
- ClkEn_e  out  1  datapath clock enable (register file and carry flip-flop)
- RegMux_c  out  2  writeback select: 00 ALU, 01 data, 10 port
- op2_c  out  1  0 = rs2, 1 = immediate
- halted_o  out  1  core is in standby

## Operation
States are FETCH, DECODE, EXECUTE, MEM and HALT.

- **FETCH**
  - Drive inst_cyc_o = inst_stb_o = 1 and inst_adr_o = PC.
  - Hold there until inst_ack_i.
  - On ack: PC <= PC+1 (wraps modulo 2^PC_W), then go to DECODE.
- **DECODE** (one cycle)
  - Register the class and func_e.
  - op2_c = 1 for alu_imm, and for shift when func_e[2] = 1. Otherwise op2_c = 0.
  - op2_c holds its value through EXECUTE.
- **EXECUTE** (one cycle), by class:
  - **alu_reg, alu_imm, shift**
    - ClkEn_e = 1, RegWrt_c = 1, RegMux_c = 00.
    - Latch zero_e and carry_e into the internal Z and C flags.
    - Next state: FETCH.
  - **branch**
    - Condition by func_e[1:0]: 00 Z, 01 !Z, 10 C, 11 !C.
    - If the condition is true: PC <= PC + sext(disp_e).
    - Next state: FETCH.
  - **jump**
    - func_e[0] = 0 (jmp): PC <= addr_e.
    - func_e[0] = 1 (jsb): push PC (already incremented), then PC <= addr_e.
    - Next state: FETCH.
  - **misc**
    - func_e 000 (ret): pop into PC, then FETCH.
    - func_e 001 (stby): go to HALT.
    - Any other func_e: no operation, then FETCH.
  - **mem**: go to MEM.
  - **Empty op_e** (all zero) or a non-one-hot op_e: treated as a no-operation, then FETCH.
- **MEM**, by func_e[1:0]:
  - 00 ldm: data_stb_o = 1, data_we_o = 0.
  - 01 stm: data_stb_o = 1, data_we_o = 1.
  - 10 inp: port_stb_o = 1, port_we_o = 0.
  - 11 out: port_stb_o = 1, port_we_o = 1.
  - Strobes stay high until the matching ack.
  - In the ack cycle:
    - ldm: RegWrt_c = 1, ClkEn_e = 1, RegMux_c = 01.
    - inp: RegWrt_c = 1, ClkEn_e = 1, RegMux_c = 10.
    - stm and out: no register write.
  - Next state: FETCH.
- **HALT**
  - halted_o = 1 and all strobes stay low.
  - Only reset leaves HALT.
- **Return stack**
  - Circular buffer with a 3-bit pointer (log2 RSTACK_DEPTH).
  - A push onto a full stack overwrites the oldest entry.
  - A pop from an empty stack returns whatever entry the pointer wraps to. There is no error flag.
- **Arithmetic**
  - sext(disp_e) is sign-extended to PC_W bits.
  - The PC sum is taken modulo 2^PC_W.

## Timing
- **Reset values** (asynchronous, while rst_i = 0):
  - State = FETCH, PC = 0, stack pointer = 0, Z = C = 0.
  - Every output is 0, including inst_stb_o, RegWrt_c, ClkEn_e, op2_c and halted_o.
- **First cycle after rst_i rises**: inst_stb_o = 1 with inst_adr_o = 0.
- **Reset mid-operation**: a bus cycle is abandoned immediately and the strobe drops asynchronously.
- **All outputs are registered or decoded from state.** No combinational path from any *_ack_i input to any *_stb_o output.
- **Ack arrival**: an ack is accepted only while the matching strobe is high. A stray ack in any other state is ignored.
- **Latency with zero-wait acks**:
  - ALU, branch, jump and misc: 3 cycles (FETCH, DECODE, EXECUTE).
  - mem: 4 cycles.
- **Stalls**: each wait cycle on an ack adds one cycle and holds all outputs stable.
- **Strobe pulses**: ClkEn_e and RegWrt_c are single-cycle pulses, asserted only in the writeback cycle.
- **Flag update vs. branch**: a flag update and a branch never occur in the same cycle. A branch uses the flags from the most recent ALU instruction.
- **Simultaneous acks**: if data_ack_i and port_ack_i both assert, only the ack matching the active strobe counts.

## Test plan
1. **Reset/fetch**: hold rst_i low, release, ack the first fetch after 2 wait cycles -> inst_adr_o = 0 for 3 cycles; inst_adr_o = 1 on the next FETCH.
2. **ALU then branch**: alu_imm with zero_e = 1, carry_e = 0 at PC 0x010, then bz with disp_e = 0xFC -> op2_c = 1 during the ALU op, one-cycle RegWrt_c/ClkEn_e pulse; the branch sets PC to 0x012 - 4 = 0x00E. bnc is also taken; bc is not taken (PC advances by one).
3. **Subroutine nesting**: 9 nested jsb, then 9 ret -> the first 8 rets return the correct addresses in LIFO order; the 9th returns the wrapped (overwritten) entry. PC wraps from 0xFFF to 0x000 on an increment.
4. **Memory/port**: ldm with a 3-cycle data_ack delay -> data_stb_o held 3 cycles; RegMux_c = 01 and RegWrt_c pulse in the ack cycle. out with an immediate ack -> port_we_o = 1 and no RegWrt_c.
5. **Mid-operation reset and standby**: assert rst_i low while data_stb_o is high -> strobe drops immediately and PC = 0. stby -> halted_o = 1 and no strobes for 100 cycles, until the next reset.
6. **Illegal class**: op_e = 0 and op_e = 0x03 -> treated as a no-operation; no RegWrt_c, PC + 1.
